lbp_hist: RTL and testbench
===========================

Name: lbp_hist

Overview:
- Sits directly downstream of the LBP stage and consumes its lbp_addr/lbp_valid/lbp_data write stream for one 128x128 image.
- Accumulates a 256-bin histogram of LBP codes.
- On the producer's finish indication, streams all 256 bin counts out over a valid/ready interface, then raises done.
- Feeds the texture-descriptor stage and the testbench golden compare.

Parameters:
- CNT_W, 15, bin counter width (holds 0..16384).
- EXCL_BORDER, 0, when 1 ignore samples whose row or col is 0 or 127.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- lbp_valid  in  1  producer write strobe
- lbp_addr  in  14  pixel address {row[13:7], col[6:0]}
- lbp_data  in  8  LBP code = bin index
- lbp_finish  in  1  producer finished; level, stays high
- hist_valid  out  1  bin count presented
- hist_ready  in  1  consumer accepts a bin when hist_valid && hist_ready
- hist_bin  out  8  bin index
- hist_count  out  CNT_W  bin count
- pix_count  out  15  number of samples counted
- done  out  1  all 256 bins accepted; sticky until reset

Behaviour:
- Clocking and reset:
  - clk is the clock. reset is asynchronous, active-high.
  - Reset clears all 256 bins, pix_count, last-address tracking, hist_valid, hist_bin, hist_count and done to 0. State goes to ACCUM.
  - Reset mid-DUMP aborts the dump. The next image starts from cleared bins.
- States: ACCUM -> DRAIN -> DUMP -> DONE.
- ACCUM, sample qualification:
  - A cycle is a sample when lbp_valid=1 and lbp_finish=0.
  - The producer may hold lbp_valid high for several cycles with unchanged lbp_addr/lbp_data. Count exactly one event per distinct address.
  - Rule: count when (no sample counted yet) or (lbp_addr != last_addr).
  - last_addr updates on every counted sample.
  - Samples arriving after lbp_finish=1 are ignored, even if lbp_valid is still high.
- ACCUM, counting:
  - A counted sample increments bin[lbp_data] and pix_count in the same cycle; the bin is updated at the clock edge.
  - Back-to-back samples with the same code on consecutive cycles must each increment; no read-modify-write hazard is allowed.
  - With EXCL_BORDER=1, border samples still update last_addr but do not increment the bin or pix_count.
  - Bins saturate at 2^CNT_W-1. pix_count saturates at 32767.
- ACCUM exit: lbp_finish=1 -> DRAIN.
- DRAIN: exactly one cycle, so the final increment settles; then -> DUMP with the bin index at 0.
- DUMP:
  - hist_valid=1, hist_bin=index, hist_count=bin[index], all registered outputs.
  - On hist_valid && hist_ready: index increments and the next bin appears the following cycle. Zero-bubble streaming at 1 bin/cycle when hist_ready is held high.
  - hist_ready=0: outputs hold stable; index, hist_bin and hist_count do not change.
  - Acceptance of bin 255 -> DONE.
- DONE:
  - hist_valid=0 from the next cycle; done=1.
  - No further counting until reset; lbp_valid is ignored.
- Latency: lbp_finish rising to first hist_valid = 2 cycles (DRAIN, then DUMP register).
- The bin sum over all bins always equals pix_count (no saturation case).

Test Plan:
- Uniform image (all codes 0xFF), EXCL_BORDER=0, 16384 single-cycle samples, then finish -> bin255=16384, all other bins 0, pix_count=16384, 256 beats streamed with hist_ready=1, done after beat 255.
- Producer holds lbp_valid 2 cycles per interior pixel (same addr/data), border pixels 1 cycle each, codes = col[7:0] -> each pixel counted once; pix_count=16384; bin0=128 (col 0), every bin 1..127 = 128.
- Same code (0x3C) on consecutive cycles at different addresses, 5 samples -> bin 0x3C=5.
- lbp_finish asserted while lbp_valid stays high with a new addr/code 0x11 -> bin 0x11 unchanged; first hist_valid exactly 2 cycles after finish.
- DUMP with hist_ready toggling 1,0,0,1 -> hist_bin sequence 0,1,1,1,2; hist_count stable while stalled; no bin skipped or repeated.
- EXCL_BORDER=1, full 128x128 stream with border code 0 and interior code 5 -> bin5=15876, bin0=0, pix_count=15876; reset asserted at DUMP bin 100 -> hist_valid=0, done=0, all bins 0 afterward.

Source files
------------

// File: rtl/lbp_hist_if.sv
// Stream bundle between the LBP producer, the histogram block and the bin consumer.
// The slave modport is the histogram block; the master modport is the producer/consumer side.
interface lbp_hist_if #(
  parameter int CNT_W = 15
);
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             lbp_finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [14:0]      pix_count;
  logic             done;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
    input  hist_valid, hist_bin, hist_count, pix_count, done
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
    output hist_valid, hist_bin, hist_count, pix_count, done
  );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin LBP code histogram for one 128x128 image; counts each distinct address once,
// then streams every bin count over valid/ready and raises a sticky done.
module lbp_hist #(
  parameter int CNT_W       = 15,
  parameter bit EXCL_BORDER = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  lbp_hist_if.slave  hif
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BIN_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BIN_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] BIN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [14:0]      PIX_MAX  = 15'h7FFF;

  state_t           r_state;
  logic [CNT_W-1:0] r_bins [256];
  logic             r_seen;
  logic [13:0]      r_last_addr;
  logic [14:0]      r_pix;
  logic [7:0]       r_idx;
  logic             r_hist_valid;
  logic [7:0]       r_hist_bin;
  logic [CNT_W-1:0] r_hist_count;
  logic             r_done;

  logic [6:0]       w_row;
  logic [6:0]       w_col;
  logic             w_sample;
  logic             w_new;
  logic             w_border;
  logic             w_inc;
  logic             w_accept;
  logic [7:0]       w_next_idx;

  assign w_row      = hif.lbp_addr[13:7];
  assign w_col      = hif.lbp_addr[6:0];
  assign w_sample   = (r_state == ST_ACCUM) && hif.lbp_valid && !hif.lbp_finish;
  // A held strobe on the same address is one pixel; only a changed address is a new event.
  assign w_new      = w_sample && (!r_seen || (hif.lbp_addr != r_last_addr));
  assign w_border   = (w_row == 7'd0) || (w_row == 7'd127) || (w_col == 7'd0) || (w_col == 7'd127);
  assign w_inc      = w_new && !(EXCL_BORDER && w_border);
  assign w_accept   = r_hist_valid && hif.hist_ready;
  assign w_next_idx = r_idx + 8'd1;

  // Bin storage: each bin is its own register, so consecutive same-code hits never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        r_bins[i] <= BIN_ZERO;
      end
    end else if (w_inc && (r_bins[hif.lbp_data] != BIN_MAX)) begin
      r_bins[hif.lbp_data] <= r_bins[hif.lbp_data] + BIN_ONE;
    end
  end

  // Control FSM: accumulate, one settle cycle, stream bins, then hold done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ACCUM;
      r_seen       <= 1'b0;
      r_last_addr  <= 14'd0;
      r_pix        <= 15'd0;
      r_idx        <= 8'd0;
      r_hist_valid <= 1'b0;
      r_hist_bin   <= 8'd0;
      r_hist_count <= BIN_ZERO;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_new) begin
            r_seen      <= 1'b1;
            r_last_addr <= hif.lbp_addr;
          end
          if (w_inc && (r_pix != PIX_MAX)) begin
            r_pix <= r_pix + 15'd1;
          end
          if (hif.lbp_finish) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_idx        <= 8'd0;
          r_hist_valid <= 1'b1;
          r_hist_bin   <= 8'd0;
          r_hist_count <= r_bins[8'd0];
          r_state      <= ST_DUMP;
        end
        ST_DUMP: begin
          if (w_accept) begin
            if (r_idx == 8'd255) begin
              r_hist_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_idx        <= w_next_idx;
              r_hist_bin   <= w_next_idx;
              r_hist_count <= r_bins[w_next_idx];
            end
          end
        end
        ST_DONE: begin
          r_hist_valid <= 1'b0;
          r_done       <= 1'b1;
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign hif.hist_valid = r_hist_valid;
  assign hif.hist_bin   = r_hist_bin;
  assign hif.hist_count = r_hist_count;
  assign hif.pix_count  = r_pix;
  assign hif.done       = r_done;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: directed images push hand-computed bin counts into
// per-instance queues; negedge monitors pop and compare every accepted beat.
module tb_lbp_hist;
  localparam int CNT_W = 15;

  typedef struct {
    int bin;
    int cnt;
  } beat_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  lbp_hist_if #(.CNT_W(CNT_W)) if_a ();
  lbp_hist_if #(.CNT_W(CNT_W)) if_b ();

  lbp_hist #(.CNT_W(CNT_W), .EXCL_BORDER(1'b0)) dut_a (.clk(clk), .reset(rst_a), .hif(if_a.slave));
  lbp_hist #(.CNT_W(CNT_W), .EXCL_BORDER(1'b1)) dut_b (.clk(clk), .reset(rst_b), .hif(if_b.slave));

  int    n_vec = 0;
  int    n_err = 0;
  beat_t q_a[$];
  beat_t q_b[$];
  beat_t e_a;
  beat_t e_b;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input bit sel, input int bin, input int cnt);
    beat_t b;
    b.bin = bin;
    b.cnt = cnt;
    if (sel) q_b.push_back(b);
    else     q_a.push_back(b);
  endfunction

  // Monitor for instance A
  always @(negedge clk) begin
    if (if_a.hist_valid && if_a.hist_ready) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_extra_beat: got bin %0d, expected no beat", if_a.hist_bin);
      end else begin
        e_a = q_a.pop_front();
        chk("a_bin", int'(if_a.hist_bin), e_a.bin);
        chk("a_count", int'(if_a.hist_count), e_a.cnt);
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (if_b.hist_valid && if_b.hist_ready) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_extra_beat: got bin %0d, expected no beat", if_b.hist_bin);
      end else begin
        e_b = q_b.pop_front();
        chk("b_bin", int'(if_b.hist_bin), e_b.bin);
        chk("b_count", int'(if_b.hist_count), e_b.cnt);
      end
    end
  end

  task automatic send(input bit sel, input logic [13:0] addr, input logic [7:0] data, input int hold);
    if (sel) begin
      if_b.lbp_valid = 1'b1;
      if_b.lbp_addr  = addr;
      if_b.lbp_data  = data;
    end else begin
      if_a.lbp_valid = 1'b1;
      if_a.lbp_addr  = addr;
      if_a.lbp_data  = data;
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ((sel ? if_b.done : if_a.done) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b1;
    if_a.lbp_valid  = 1'b0;
    if_a.lbp_finish = 1'b0;
    if_a.hist_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] r7;
    logic [6:0] c7;
    bit         brd;
    int         pat_rdy [5] = '{1, 0, 0, 1, 1};
    int         seq_bin [5] = '{0, 1, 1, 1, 2};
    bit         hit;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.lbp_valid = 1'b0; if_a.lbp_addr = 14'd0; if_a.lbp_data = 8'd0;
    if_a.lbp_finish = 1'b0; if_a.hist_ready = 1'b0;
    if_b.lbp_valid = 1'b0; if_b.lbp_addr = 14'd0; if_b.lbp_data = 8'd0;
    if_b.lbp_finish = 1'b0; if_b.hist_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_hist_valid", int'(if_a.hist_valid), 0);
    chk("rst_done", int'(if_a.done), 0);
    chk("rst_pix", int'(if_a.pix_count), 0);
    chk("rst_bin", int'(if_a.hist_bin), 0);
    chk("rst_count", int'(if_a.hist_count), 0);
    @(posedge clk);
    #1;

    // Uniform image, every code 0xFF
    for (int i = 0; i < 16384; i++) send(1'b0, 14'(i), 8'hFF, 1);
    if_a.lbp_valid = 1'b0;
    for (int b = 0; b < 256; b++) push_exp(1'b0, b, (b == 255) ? 16384 : 0);
    if_a.hist_ready = 1'b1;
    if_a.lbp_finish = 1'b1;
    wait_done(1'b0, "uni_done");
    chk("uni_pix", int'(if_a.pix_count), 16384);
    chk("uni_valid_low", int'(if_a.hist_valid), 0);
    chk("uni_queue_empty", q_a.size(), 0);
    pulse_reset_a();

    // Held strobes on interior pixels, codes equal to column
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        r7 = r[6:0];
        c7 = c[6:0];
        brd = (r == 0) || (r == 127) || (c == 0) || (c == 127);
        send(1'b0, {r7, c7}, {1'b0, c7}, brd ? 1 : 2);
      end
    end
    if_a.lbp_valid = 1'b0;
    for (int b = 0; b < 256; b++) push_exp(1'b0, b, (b < 128) ? 128 : 0);
    if_a.hist_ready = 1'b1;
    if_a.lbp_finish = 1'b1;
    wait_done(1'b0, "hold_done");
    chk("hold_pix", int'(if_a.pix_count), 16384);
    chk("hold_queue_empty", q_a.size(), 0);
    pulse_reset_a();

    // Same code back-to-back, then finish while valid stays high with a new code
    for (int k = 0; k < 5; k++) send(1'b0, 14'(k), 8'h3C, 1);
    for (int b = 0; b < 256; b++) push_exp(1'b0, b, (b == 8'h3C) ? 5 : 0);
    if_a.lbp_addr   = 14'd5;
    if_a.lbp_data   = 8'h11;
    if_a.lbp_finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_drain_valid", int'(if_a.hist_valid), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if_a.hist_ready = pat_rdy[k][0];
      @(negedge clk);
      chk("stall_valid", int'(if_a.hist_valid), 1);
      chk("stall_bin", int'(if_a.hist_bin), seq_bin[k]);
      chk("stall_count", int'(if_a.hist_count), 0);
      @(posedge clk);
      #1;
    end
    chk("finish_pix", int'(if_a.pix_count), 5);
    wait_done(1'b0, "stall_done");
    chk("stall_queue_empty", q_a.size(), 0);
    if_a.lbp_valid = 1'b0;

    // Border exclusion, then reset in the middle of the dump
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        r7 = r[6:0];
        c7 = c[6:0];
        brd = (r == 0) || (r == 127) || (c == 0) || (c == 127);
        send(1'b1, {r7, c7}, brd ? 8'd0 : 8'd5, 1);
      end
    end
    if_b.lbp_valid = 1'b0;
    for (int b = 0; b <= 100; b++) push_exp(1'b1, b, (b == 5) ? 15876 : 0);
    if_b.hist_ready = 1'b1;
    if_b.lbp_finish = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (if_b.hist_valid && (if_b.hist_bin == 8'd100)) begin
        hit = 1'b1;
        break;
      end
    end
    chk("excl_reach_bin100", int'(hit), 1);
    chk("excl_pix", int'(if_b.pix_count), 15876);
    #1;
    rst_b = 1'b1;
    #1;
    chk("abort_valid", int'(if_b.hist_valid), 0);
    chk("abort_done", int'(if_b.done), 0);
    chk("abort_pix", int'(if_b.pix_count), 0);
    chk("abort_queue_empty", q_b.size(), 0);
    for (int b = 0; b < 256; b++) push_exp(1'b1, b, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    wait_done(1'b1, "cleared_done");
    chk("cleared_pix", int'(if_b.pix_count), 0);
    chk("cleared_queue_empty", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
